// File: rtl/leve_pipe_pkg.sv
// Shared types for the LEVE pipeline sequencing/hazard controller.
package leve_pipe_pkg;

  localparam int LEVE_NREG = 32;
  localparam int LEVE_RDW  = 5;

  typedef struct packed {
    logic                valid;
    logic                rd_we;
    logic [LEVE_RDW-1:0] rd;
  } pstage_t;

endpackage

// File: rtl/leve_pipe_sb.sv
// Scoreboard comparator: flags a read-after-write hazard against in-flight stages.
// LEVE_RF_BYPASS_EN: the writeback stage forwards, so it is left out of the compare.
module leve_pipe_sb
  import leve_pipe_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  pstage_t [STAGES-1:0] stg,
  input  logic                 rs1_use,
  input  logic [4:0]           rs1,
  input  logic                 rs2_use,
  input  logic [4:0]           rs2,
  output logic                 hazard
);

`ifdef LEVE_RF_BYPASS_EN
  localparam int NCMP = STAGES - 1;
`else
  localparam int NCMP = STAGES;
`endif

  // r0 is hardwired to zero, so a write to it never produces a value to wait for.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NCMP; k++) begin
      if (stg[k].valid && stg[k].rd_we && (stg[k].rd != '0) &&
          ((rs1_use && (stg[k].rd == rs1)) || (rs2_use && (stg[k].rd == rs2))))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/leve_pipe_ctl.sv
// LEVE pipeline sequencing and hazard controller: per-stage valid/rd tracking,
// RAW issue stall, branch-redirect kill, saturating stall counter. Macro: LEVE_RF_BYPASS_EN.
module leve_pipe_ctl
  import leve_pipe_pkg::*;
#(
  parameter int STAGES   = 4,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_RD_WE,
  input  logic [4:0]        IN_RD,
  input  logic              IN_RS1_USE,
  input  logic              IN_RS2_USE,
  input  logic [4:0]        IN_RS1,
  input  logic [4:0]        IN_RS2,
  input  logic              REDIRECT,
  output logic [STAGES-1:0] VALID,
  output logic              WB_WE,
  output logic [4:0]        WB_RD,
  output logic              RETIRE,
  output logic [CNT_W-1:0]  STALL_CNT
);

  pstage_t [STAGES-1:0] stg;
  pstage_t [STAGES-1:0] stg_nxt;
  logic                 hazard;
  logic                 issue;
  logic [CNT_W-1:0]     cnt;

  leve_pipe_sb #(.STAGES(STAGES)) u_sb (
    .stg     (stg),
    .rs1_use (IN_RS1_USE),
    .rs1     (IN_RS1),
    .rs2_use (IN_RS2_USE),
    .rs2     (IN_RS2),
    .hazard  (hazard)
  );

  // Issue handshake: an instruction enters stage 0 on a rising edge where
  // IN_VALID and IN_READY are both high. IN_READY never looks at IN_VALID,
  // and IN_VALID may be dropped or changed at any time without penalty.
  assign IN_READY = !RST && !REDIRECT && !hazard;
  assign issue    = IN_VALID && IN_READY;

  // Stages advance every cycle; a redirect clears everything younger than the branch.
  always_comb begin
    stg_nxt = '0;
    if (issue)
      stg_nxt[0] = {1'b1, IN_RD_WE, IN_RD};
    for (int k = 1; k < STAGES; k++) begin
      if (REDIRECT && (k <= BR_STAGE))
        stg_nxt[k] = '0;
      else
        stg_nxt[k] = stg[k-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stg <= '0;
    else
      stg <= stg_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (IN_VALID && hazard && !REDIRECT && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_valid
    assign VALID[k] = stg[k].valid;
  end

  assign RETIRE    = stg[STAGES-1].valid;
  assign WB_WE     = stg[STAGES-1].valid && stg[STAGES-1].rd_we;
  assign WB_RD     = stg[STAGES-1].rd;
  assign STALL_CNT = cnt;

endmodule

// File: doc/leve_pipe_ctl.md
# leve_pipe_ctl

Parametrised pipeline sequencing and hazard controller for the LEVE core. It tracks per-stage valid bits and destination registers from decode entry to writeback, stalls issue on read-after-write hazards and kills younger stages on a branch redirect. It replaces the fixed, unstallable valid_sN shift chain with one configurable block, so deeper cores with different branch-resolve stages can reuse it.

## Interface
- STAGES, 4, tracked stages from issue (stage 0) to writeback (stage STAGES-1); legal range 2..8
- BR_STAGE, 2, stage holding a resolving branch; stages below it are killed on redirect; 1 ≤ BR_STAGE ≤ STAGES-1
- CNT_W, 32, stall counter width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  decoded instruction offered for issue
- IN_READY  out  1  issue accepted this cycle (combinational)
- IN_RD_WE  in  1  instruction writes a GPR
- IN_RD  in  5  destination register
- IN_RS1_USE, IN_RS2_USE  in  1 each  source operand is a register read
- IN_RS1, IN_RS2  in  5 each  source registers
- REDIRECT  in  1  branch in BR_STAGE mispredicted/taken; flush younger stages
- VALID  out  STAGES  per-stage valid, bit k = stage k
- WB_WE  out  1  stage STAGES-1 valid and writes a GPR
- WB_RD  out  5  destination of stage STAGES-1
- RETIRE  out  1  stage STAGES-1 valid
- STALL_CNT  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Each stage k holds {valid, rd_we, rd}. Every cycle, stage k+1 takes stage k unconditionally; stages never stall individually (fixed latency after issue).
- Stage 0 loads {1, IN_RD_WE, IN_RD} when IN_VALID && IN_READY, else {0, x, x}.
- Hazard: some stage k in the compare range has valid && rd_we && rd != 0 && rd equals IN_RS1 (with IN_RS1_USE) or IN_RS2 (with IN_RS2_USE). Register 0 never creates a hazard.
- IN_READY = !RST && !REDIRECT && !hazard. It is independent of IN_VALID.
- REDIRECT at an edge: stages 1..BR_STAGE are loaded with valid=0 (they would receive killed stages 0..BR_STAGE-1); stage 0 loads 0 since issue is blocked; stage BR_STAGE+1 receives the branch itself normally. Redirect with no valid instruction in BR_STAGE is still obeyed.
- STALL_CNT increments on cycles with IN_VALID && hazard && !REDIRECT; it holds at all-ones and never wraps.
- WB_WE, WB_RD, RETIRE are decoded from the stage STAGES-1 register (no combinational path from inputs).

## Timing
- Issue accepted at edge t → VALID[k] high during cycle t+1+k; RETIRE during cycle t+STAGES.
- Redirect at edge t → killed bits are 0 from cycle t+1; any hazard they caused clears the same cycle.
- Reset: VALID=0, WB_WE=0, WB_RD=0, RETIRE=0, STALL_CNT=0 immediately on RST rising, held while high; IN_READY=0 while RST. First issue is possible on the first edge after RST falls.
- Simultaneous IN_VALID and REDIRECT: no issue; no stall count.

## Configuration
- LEVE_RF_BYPASS_EN defined: the register file forwards writeback data, so the compare range is stages 0..STAGES-2; a producer in the writeback stage does not stall.
- Undefined: compare range is stages 0..STAGES-1; a consumer waits until the producer has left writeback.

## Structure
- Package leve_pipe_pkg: typedef pstage_t {valid, rd_we, rd[4:0]}; constants LEVE_NREG=32, LEVE_RDW=5.
- Sub-module leve_pipe_sb: the scoreboard comparator. It takes the pstage_t array plus sources and returns hazard. The top holds the stage registers, kill logic and counter.

## Test plan
- STAGES=4, four independent issues (rd=1..4, no sources) on back-to-back edges → IN_READY stays 1; VALID 0001, 0011, 0111, 1111; RETIRE first high 4 cycles after first issue; STALL_CNT=0.
- RAW: issue rd=5, then offer rs1=5 → without bypass IN_READY low 4 cycles, STALL_CNT=4; with LEVE_RF_BYPASS_EN low 3 cycles, STALL_CNT=3.
- Producer rd=0 with IN_RD_WE=1, consumer rs1=0, rs2 use=1 rs2=0 → no stall, STALL_CNT=0.
- Full pipe, REDIRECT one cycle with BR_STAGE=2 → next cycle VALID=1000 (only the branch, now in stage 3, survives); IN_READY low during the REDIRECT cycle; STALL_CNT unchanged.
- Producer rd=7 in stage 1, consumer rs2=7 stalled; REDIRECT → consumer accepted at the first edge after the redirect cycle.
- CNT_W=3: persistent hazard for 10 cycles → STALL_CNT reads 7 and holds. Assert RST mid-run with pipe full → VALID=0, STALL_CNT=0 and IN_READY=0 without waiting for a clock edge.
